// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants and types for the Lou-CPU pipeline
//
// Purpose : register file width/depth constants, the zero-register address
//           and the address/word typedefs used by the decode stage.
// Ports   : none (package)
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] word_t;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port of the register file
//
// Purpose : masks address 0 to zero, optionally forwards same-edge write
//           data, and holds the registered output while decode is stalled.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           i_ra             - read address sampled on the rising edge
//           i_mem_data       - storage content at i_ra (pre-write)
//           i_stall          - hold o_rd, ignore i_ra
//           i_we/i_wa/i_wdat - writeback port, present only with REGFILE_BYPASS_EN
//           o_rd             - registered read data
// Config  : REGFILE_BYPASS_EN - same-edge write to the read address returns i_wdat
module regfile_rd_port
    import cpu_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_ra,
    input  logic [DW-1:0] i_mem_data,
    input  logic          i_stall,
`ifdef REGFILE_BYPASS_EN
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wdat,
`endif
    output logic [DW-1:0] o_rd
);

    logic          w_is_zero;
    logic [DW-1:0] w_next;
    logic [DW-1:0] r_rd;

    assign w_is_zero = (i_ra == AW'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    // A write in flight to the same address wins over the stored value;
    // writes to address 0 never forward because the zero mask comes first.
    logic w_hit;
    assign w_hit  = i_we && (i_wa == i_ra);
    assign w_next = w_is_zero ? '0 : (w_hit ? i_wdat : i_mem_data);
`else
    assign w_next = w_is_zero ? '0 : i_mem_data;
`endif

    // Stall gates the register enable, so an unknown address during a stall
    // never reaches the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
        end else if (!i_stall) begin
            r_rd <= w_next;
        end
    end

    assign o_rd = r_rd;

endmodule

// File: rtl/reg_file_rd.sv
// rtl/reg_file_rd.sv - 2-read / 1-write register file with registered read ports
//
// Purpose : general-purpose register file for decode; entry 0 reads as zero,
//           reads are registered, stall freezes the read outputs.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           RegWrite     - write enable from writeback
//           wa, wdat     - write address / data
//           ra1, ra2     - read addresses
//           stall        - hold rd1/rd2/rvalid, writes still complete
//           rd1, rd2     - registered read data
//           rvalid       - rd1/rd2 hold data for a previously sampled address
// Config  : REGFILE_BYPASS_EN - same-edge write/read of one address returns wdat
module reg_file_rd
    import cpu_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RegWrite,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wdat,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          stall,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          rvalid
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic          r_rvalid;
    logic          w_we;
    logic [DW-1:0] w_mem_rd1;
    logic [DW-1:0] w_mem_rd2;

    // Entry 0 is never written, so it stays at its reset value of zero.
    assign w_we = RegWrite && (wa != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[wa] <= wdat;
        end
    end

    assign w_mem_rd1 = r_mem[ra1];
    assign w_mem_rd2 = r_mem[ra2];

    regfile_rd_port #(.DW(DW), .AW(AW)) u_port1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ra       (ra1),
        .i_mem_data (w_mem_rd1),
        .i_stall    (stall),
`ifdef REGFILE_BYPASS_EN
        .i_we       (w_we),
        .i_wa       (wa),
        .i_wdat     (wdat),
`endif
        .o_rd       (rd1)
    );

    regfile_rd_port #(.DW(DW), .AW(AW)) u_port2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ra       (ra2),
        .i_mem_data (w_mem_rd2),
        .i_stall    (stall),
`ifdef REGFILE_BYPASS_EN
        .i_we       (w_we),
        .i_wa       (wa),
        .i_wdat     (wdat),
`endif
        .o_rd       (rd2)
    );

    // Once set, rvalid only falls on reset; a stalled edge leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
        end else if (!stall) begin
            r_rvalid <= 1'b1;
        end
    end

    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_reg_file_rd.sv
// tb/tb_reg_file_rd.sv - self-checking bench for reg_file_rd
module tb_reg_file_rd;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  wa;
    logic [31:0] wdat;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        stall;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        rvalid;

    reg_file_rd #(.DW(32), .AW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RegWrite (RegWrite),
        .wa       (wa),
        .wdat     (wdat),
        .ra1      (ra1),
        .ra2      (ra2),
        .stall    (stall),
        .rd1      (rd1),
        .rd2      (rd2),
        .rvalid   (rvalid)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: plain array of register contents plus expected outputs.
    logic [31:0] m_mem [32];
    logic [31:0] m_rd1, m_rd2;
    logic        m_rv;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wdat;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        stall;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_rv;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic we, logic [4:0] a_w, logic [31:0] d,
                                logic [4:0] a1, logic [4:0] a2, logic st,
                                logic [31:0] e1, logic [31:0] e2, logic ev);
        vec_t v;
        v.we = we; v.wa = a_w; v.wdat = d; v.ra1 = a1; v.ra2 = a2; v.stall = st;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_rv = ev;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_rd1 = '0; m_rd2 = '0; m_rv = 1'b0;
    endtask

    function automatic logic [31:0] mread(logic [4:0] a);
        if (a == 5'd0) return '0;
        if (BYP && RegWrite && wa == a) return wdat;
        return m_mem[a];
    endfunction

    // Apply one clock edge with the currently driven inputs; the model is
    // advanced from the same pre-edge inputs, outputs are sampled 1 time unit later.
    task automatic tick();
        if (!stall) begin
            m_rd1 = mread(ra1);
            m_rd2 = mread(ra2);
            m_rv  = 1'b1;
        end
        if (RegWrite && wa != 5'd0) m_mem[wa] = wdat;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".rd1"}, rd1, m_rd1);
        chk({tag, ".rd2"}, rd2, m_rd2);
        chk({tag, ".rvalid"}, {31'b0, rvalid}, {31'b0, m_rv});
    endtask

    task automatic drive(logic we, logic [4:0] a_w, logic [31:0] d,
                         logic [4:0] a1, logic [4:0] a2, logic st);
        RegWrite = we; wa = a_w; wdat = d; ra1 = a1; ra2 = a2; stall = st;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset.rd1", rd1, 32'h0);
        chk("reset.rd2", rd2, 32'h0);
        chk("reset.rvalid", {31'b0, rvalid}, 32'h0);
        rst_n = 1'b1;

        // First edge after reset is stalled: rvalid must stay low.
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1);
        tick();
        chk("first_stall.rvalid", {31'b0, rvalid}, 32'h0);

        // Directed table: write/read, zero register, same-edge hazard, stall.
        tv.push_back(mk(1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 0, 32'h0, 32'h0, 1));
        tv.push_back(mk(0, 5'd0, 32'h0,        5'd5, 5'd5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1));
        tv.push_back(mk(1, 5'd0, 32'h12345678, 5'd0, 5'd0, 0, 32'h0, 32'h0, 1));
        tv.push_back(mk(0, 5'd0, 32'h0,        5'd0, 5'd0, 0, 32'h0, 32'h0, 1));
        tv.push_back(mk(1, 5'd7, 32'h1,        5'd5, 5'd0, 0, 32'hDEADBEEF, 32'h0, 1));
        tv.push_back(mk(1, 5'd7, 32'h2,        5'd0, 5'd7, 0, 32'h0, BYP ? 32'h2 : 32'h1, 1));
        tv.push_back(mk(0, 5'd0, 32'h0,        5'd7, 5'd7, 0, 32'h2, 32'h2, 1));
        tv.push_back(mk(1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd0, 0, 32'h0, 32'h0, 1));
        tv.push_back(mk(0, 5'd0, 32'h0,        5'd9, 5'd5, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 1));
        tv.push_back(mk(1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3, 1, 32'hA5A5A5A5, 32'hDEADBEEF, 1));
        tv.push_back(mk(0, 5'd0, 32'h0,        5'd7, 5'd3, 1, 32'hA5A5A5A5, 32'hDEADBEEF, 1));
        tv.push_back(mk(1, 5'd3, 32'h0BADF00D, 5'd1, 5'd2, 1, 32'hA5A5A5A5, 32'hDEADBEEF, 1));
        tv.push_back(mk(0, 5'd0, 32'h0,        5'd3, 5'd9, 0, 32'h0BADF00D, 32'hA5A5A5A5, 1));
        foreach (tv[k]) begin
            drive(tv[k].we, tv[k].wa, tv[k].wdat, tv[k].ra1, tv[k].ra2, tv[k].stall);
            tick();
            chk($sformatf("vec%0d.rd1", k), rd1, tv[k].e_rd1);
            chk($sformatf("vec%0d.rd2", k), rd2, tv[k].e_rd2);
            chk($sformatf("vec%0d.rvalid", k), {31'b0, rvalid}, {31'b0, tv[k].e_rv});
        end

        // Unknown read addresses during stall must not disturb the outputs.
        RegWrite = 1'b0; stall = 1'b1; ra1 = 'x; ra2 = 'x;
        tick();
        chk("stall_x.rd1", rd1, 32'h0BADF00D);
        chk("stall_x.rd2", rd2, 32'hA5A5A5A5);

        // Fill 1..31 then sweep both ports in opposite directions.
        stall = 1'b0; ra1 = 5'd0; ra2 = 5'd0;
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0);
            tick();
            chk($sformatf("sweep%0d.rd1", i), rd1, 32'(i));
            chk($sformatf("sweep%0d.rd2", i), rd2, 32'(31 - i));
        end

        // Mid-cycle reset while a write is being presented.
        drive(1'b1, 5'd4, 32'h55AA55AA, 5'd4, 5'd4, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.rd1", rd1, 32'h0);
        chk("midrst.rd2", rd2, 32'h0);
        chk("midrst.rvalid", {31'b0, rvalid}, 32'h0);
        @(posedge clk); #1;
        chk("midrst_hold.rd1", rd1, 32'h0);
        chk("midrst_hold.rvalid", {31'b0, rvalid}, 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), 1'b0);
            tick();
            chk($sformatf("postrst%0d.rd1", i), rd1, 32'h0);
            chk($sformatf("postrst%0d.rd2", i), rd2, 32'h0);
        end
        chk("postrst.rvalid", {31'b0, rvalid}, 32'h1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0));
            // Bias toward same-edge hazards to exercise forwarding.
            if ($urandom_range(0, 4) == 0) ra1 = wa;
            tick();
            chk_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
